// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the instruction/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } arb_state_e;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int cnt_w(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Fixed-priority grant between fetch and data, with a starvation override for fetch.
module mem_arb_select
  import mem_arb_pkg::*;
(
  input  logic if_req,
  input  logic dm_req,
  input  logic starved,
  output logic grant_valid,
  output logic grant_owner
);

  // Data normally wins a contended slot; fetch wins once it has been starved.
  always_comb begin
    grant_valid = 1'b0;
    grant_owner = OWN_DM;
    if (if_req && dm_req) begin
      grant_valid = 1'b1;
      grant_owner = starved ? OWN_IF : OWN_DM;
    end else if (if_req) begin
      grant_valid = 1'b1;
      grant_owner = OWN_IF;
    end else if (dm_req) begin
      grant_valid = 1'b1;
      grant_owner = OWN_DM;
    end else begin
      grant_valid = 1'b0;
      grant_owner = OWN_DM;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port 64-bit RAM between instruction fetch and data memory,
// one transaction at a time, with registered read data and one-cycle ready pulses.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 6,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [63:0]       dm_wdata,
  output logic [63:0]       dm_rdata,
  output logic              dm_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  input  logic [63:0]       mem_rdata,
  output logic              busy
);

  localparam int LAT_W    = cnt_w(MEM_LAT - 1);
  localparam int STARVE_W = cnt_w(STARVE_MAX);
  localparam logic [LAT_W-1:0]    LAT_INIT   = LAT_W'(MEM_LAT - 1);
  localparam logic [STARVE_W-1:0] STARVE_TOP = STARVE_W'(STARVE_MAX);

  arb_state_e          state_r;
  logic                owner_r;
  logic                we_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [63:0]         wdata_r;
  logic [LAT_W-1:0]    lat_cnt_r;
  logic [STARVE_W-1:0] starve_cnt_r;
  logic [31:0]         if_rdata_r;
  logic [63:0]         dm_rdata_r;
  logic                if_ready_r;
  logic                dm_ready_r;
  logic                mem_en_r;
  logic                mem_we_r;
  logic                busy_r;

  logic starved_s;
  logic grant_valid_s;
  logic grant_owner_s;

  assign starved_s = (starve_cnt_r == STARVE_TOP);

  mem_arb_select u_select (
    .if_req      (if_req),
    .dm_req      (dm_req),
    .starved     (starved_s),
    .grant_valid (grant_valid_s),
    .grant_owner (grant_owner_s)
  );

  // Transaction sequencer: arbitrate, strobe the RAM once, wait out the latency, pulse ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      owner_r      <= OWN_IF;
      we_r         <= 1'b0;
      addr_r       <= '0;
      wdata_r      <= '0;
      lat_cnt_r    <= '0;
      starve_cnt_r <= '0;
      if_rdata_r   <= '0;
      dm_rdata_r   <= '0;
      if_ready_r   <= 1'b0;
      dm_ready_r   <= 1'b0;
      mem_en_r     <= 1'b0;
      mem_we_r     <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      if_ready_r <= 1'b0;
      dm_ready_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (grant_valid_s) begin
            owner_r  <= grant_owner_s;
            mem_en_r <= 1'b1;
            busy_r   <= 1'b1;
            state_r  <= ACCESS;
            if (grant_owner_s == OWN_DM) begin
              we_r     <= dm_we;
              mem_we_r <= dm_we;
              addr_r   <= dm_addr;
              wdata_r  <= dm_wdata;
              if (if_req && (starve_cnt_r != STARVE_TOP)) begin
                starve_cnt_r <= starve_cnt_r + STARVE_W'(1);
              end else begin
                starve_cnt_r <= starve_cnt_r;
              end
            end else begin
              // Fetch is always a read, whatever dm_we happens to be.
              we_r         <= 1'b0;
              mem_we_r     <= 1'b0;
              addr_r       <= if_addr;
              wdata_r      <= '0;
              starve_cnt_r <= '0;
            end
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        ACCESS: begin
          mem_en_r <= 1'b0;
          mem_we_r <= 1'b0;
          if (we_r) begin
            dm_ready_r <= (owner_r == OWN_DM);
            if_ready_r <= (owner_r == OWN_IF);
            state_r    <= DONE;
          end else begin
            lat_cnt_r <= LAT_INIT;
            state_r   <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt_r == '0) begin
            if (owner_r == OWN_DM) begin
              dm_rdata_r <= mem_rdata;
              dm_ready_r <= 1'b1;
            end else begin
              if_rdata_r <= addr_r[2] ? mem_rdata[63:32] : mem_rdata[31:0];
              if_ready_r <= 1'b1;
            end
            state_r <= DONE;
          end else begin
            lat_cnt_r <= lat_cnt_r - LAT_W'(1);
          end
        end
        DONE: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          mem_en_r <= 1'b0;
          mem_we_r <= 1'b0;
          busy_r   <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

  assign if_rdata  = if_rdata_r;
  assign if_ready  = if_ready_r;
  assign dm_rdata  = dm_rdata_r;
  assign dm_ready  = dm_ready_r;
  assign mem_en    = mem_en_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (MEM_LAT 1/3/4), each with its own latency RAM model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW   = 6;
  localparam int SMAX = 3;

  logic clk;
  logic [2:0] rst_v, if_req_v, dm_req_v, dm_we_v;
  logic [2:0] if_ready_v, dm_ready_v, mem_en_v, mem_we_v, busy_v;
  logic [2:0][AW-1:0] if_addr_v, dm_addr_v, mem_addr_v;
  logic [2:0][31:0]   if_rdata_v;
  logic [2:0][63:0]   dm_wdata_v, dm_rdata_v, mem_wdata_v, mem_rdata_v;
  logic [63:0] ref_ram [8];
  int n_pass;
  int n_total;

  function automatic logic [63:0] init_word(input int i);
    case (i)
      0:       return 64'hAAAA_BBBB_CCCC_DDDD;
      1:       return 64'hDEAD_BEEF_CAFE_F00D;
      default: return {8'h5A, 8'(i), 48'h0123_4567_89AB};
    endcase
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    logic [63:0] ram [8];
    logic [63:0] pend_r;
    logic        pend_v_r;
    int          rem_r;

    mem_port_arbiter #(.ADDR_W(AW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) u_dut (
      .clk       (clk),
      .rst       (rst_v[g]),
      .if_req    (if_req_v[g]),
      .if_addr   (if_addr_v[g]),
      .if_rdata  (if_rdata_v[g]),
      .if_ready  (if_ready_v[g]),
      .dm_req    (dm_req_v[g]),
      .dm_we     (dm_we_v[g]),
      .dm_addr   (dm_addr_v[g]),
      .dm_wdata  (dm_wdata_v[g]),
      .dm_rdata  (dm_rdata_v[g]),
      .dm_ready  (dm_ready_v[g]),
      .mem_en    (mem_en_v[g]),
      .mem_we    (mem_we_v[g]),
      .mem_addr  (mem_addr_v[g]),
      .mem_wdata (mem_wdata_v[g]),
      .mem_rdata (mem_rdata_v[g]),
      .busy      (busy_v[g])
    );

    // RAM: read data valid only LAT cycles after the strobe, poison otherwise
    always @(posedge clk) begin
      if (rst_v[g]) begin
        for (int i = 0; i < 8; i++) ram[i] <= init_word(i);
        pend_r   <= '0;
        pend_v_r <= 1'b0;
        rem_r    <= 0;
      end else if (mem_en_v[g] && mem_we_v[g]) begin
        ram[mem_addr_v[g][5:3]] <= mem_wdata_v[g];
      end else if (mem_en_v[g]) begin
        pend_r   <= ram[mem_addr_v[g][5:3]];
        pend_v_r <= 1'b1;
        rem_r    <= LAT - 1;
      end else if (pend_v_r) begin
        if (rem_r == 0) pend_v_r <= 1'b0;
        else rem_r <= rem_r - 1;
      end
    end
    assign mem_rdata_v[g] = (pend_v_r && rem_r == 0) ? pend_r : 64'h0BAD_0BAD_0BAD_0BAD;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
  endtask

  // Advance until a ready pulse of instance g; cycles = bound+1 if none arrives.
  task automatic wait_ready(input int g, input int bound, output int cycles,
                            output logic got_if, output logic got_dm, output int en_cnt);
    cycles = 0;
    en_cnt = 0;
    got_if = 1'b0;
    got_dm = 1'b0;
    while (cycles < bound) begin
      step();
      cycles++;
      en_cnt += int'(mem_en_v[g]);
      if (if_ready_v[g] || dm_ready_v[g]) begin
        got_if = if_ready_v[g];
        got_dm = dm_ready_v[g];
        break;
      end
    end
    if (!got_if && !got_dm) cycles = bound + 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc, en_cnt, scnt, exp_lat;
    logic gi, gd, win_if, if_p, dm_p, rdy_seen;
    logic [63:0] last_dm, exp_word;
    logic [7:0] order;

    n_pass = 0;
    n_total = 0;
    rst_v = 3'b111;
    if_req_v = '0;
    dm_req_v = '0;
    dm_we_v = '0;
    if_addr_v = '0;
    dm_addr_v = '0;
    dm_wdata_v = '0;
    for (int i = 0; i < 8; i++) ref_ram[i] = init_word(i);

    step();
    for (int g = 0; g < 3; g++) begin
      check($sformatf("reset_ctl%0d", g),
            64'({busy_v[g], mem_en_v[g], mem_we_v[g], if_ready_v[g], dm_ready_v[g]}), 64'd0);
      check($sformatf("reset_data%0d", g),
            dm_rdata_v[g] | mem_wdata_v[g] | 64'(if_rdata_v[g]) | 64'(mem_addr_v[g]), 64'd0);
    end
    step();
    rst_v = 3'b000;
    step();

    // Read, MEM_LAT=1: strobe at cycle 1, ready at cycle 3
    dm_req_v[0] = 1'b1; dm_we_v[0] = 1'b0; dm_addr_v[0] = 6'h08;
    step();
    check("rd_c1_en_we", 64'({mem_en_v[0], mem_we_v[0]}), 64'd2);
    check("rd_c1_addr", 64'(mem_addr_v[0]), 64'h08);
    step();
    check("rd_c2_en_rdy", 64'({mem_en_v[0], dm_ready_v[0]}), 64'd0);
    step();
    check("rd_c3_rdy", 64'(dm_ready_v[0]), 64'd1);
    check("rd_c3_data", dm_rdata_v[0], 64'hDEAD_BEEF_CAFE_F00D);
    step();
    check("rd_c4_idle", 64'({dm_ready_v[0], busy_v[0]}), 64'd0);

    // Write: strobe at cycle 1, ready at cycle 2, load data untouched
    dm_we_v[0] = 1'b1; dm_addr_v[0] = 6'h10; dm_wdata_v[0] = 64'h1234;
    step();
    check("wr_c1_en_we", 64'({mem_en_v[0], mem_we_v[0]}), 64'd3);
    check("wr_c1_wdata", mem_wdata_v[0], 64'h1234);
    check("wr_c1_addr", 64'(mem_addr_v[0]), 64'h10);
    step();
    check("wr_c2_rdy", 64'(dm_ready_v[0]), 64'd1);
    check("wr_keep_rdata", dm_rdata_v[0], 64'hDEAD_BEEF_CAFE_F00D);
    ref_ram[2] = 64'h1234;
    step();
    dm_req_v[0] = 1'b0; dm_we_v[0] = 1'b0;

    // Fetch half-select
    if_req_v[0] = 1'b1; if_addr_v[0] = 6'h04;
    wait_ready(0, 10, cyc, gi, gd, en_cnt);
    check("if_hi_lat", 64'(cyc), 64'd3);
    check("if_hi_data", 64'(if_rdata_v[0]), 64'hAAAA_BBBB);
    step();
    if_addr_v[0] = 6'h00;
    wait_ready(0, 10, cyc, gi, gd, en_cnt);
    check("if_lo_lat", 64'(cyc), 64'd3);
    check("if_lo_data", 64'(if_rdata_v[0]), 64'hCCCC_DDDD);
    step();
    if_req_v[0] = 1'b0;

    // Starvation: both held high, fetch wins every fourth grant
    order = 8'b1000_1000;
    scnt = 0;
    if_req_v[0] = 1'b1; if_addr_v[0] = 6'h04;
    dm_req_v[0] = 1'b1; dm_we_v[0] = 1'b0; dm_addr_v[0] = 6'h08;
    for (int i = 0; i < 8; i++) begin
      wait_ready(0, 10, cyc, gi, gd, en_cnt);
      check($sformatf("starve_owner%0d", i), 64'({gi, gd}), order[i] ? 64'd2 : 64'd1);
      if (order[i]) scnt = 0;
      else if (scnt < SMAX) scnt++;
      check($sformatf("starve_cnt%0d", i), 64'(g_dut[0].u_dut.starve_cnt_r), 64'(scnt));
      step();
    end
    if_req_v[0] = 1'b0; dm_req_v[0] = 1'b0;

    // Reset in WAIT with MEM_LAT=4
    dm_req_v[2] = 1'b1; dm_we_v[2] = 1'b0; dm_addr_v[2] = 6'h08;
    step(); step(); step();
    check("rstw_lat_cnt", 64'(g_dut[2].u_dut.lat_cnt_r), 64'd2);
    rst_v[2] = 1'b1; dm_req_v[2] = 1'b0;
    step();
    check("rstw_state", 64'(g_dut[2].u_dut.state_r), 64'(IDLE));
    check("rstw_ctl", 64'({busy_v[2], mem_en_v[2], mem_we_v[2], if_ready_v[2], dm_ready_v[2]}), 64'd0);
    check("rstw_data", dm_rdata_v[2] | mem_wdata_v[2] | 64'(if_rdata_v[2]) | 64'(mem_addr_v[2]), 64'd0);
    rst_v[2] = 1'b0;
    rdy_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      rdy_seen = rdy_seen | dm_ready_v[2] | mem_en_v[2];
    end
    check("rstw_no_ready", 64'(rdy_seen), 64'd0);
    dm_req_v[2] = 1'b1; dm_addr_v[2] = 6'h00;
    wait_ready(2, 14, cyc, gi, gd, en_cnt);
    check("rstw_fresh_lat", 64'(cyc), 64'd6);
    check("rstw_fresh_data", dm_rdata_v[2], 64'hAAAA_BBBB_CCCC_DDDD);
    step();
    dm_req_v[2] = 1'b0;

    // MEM_LAT=3 read with the request dropped right after the grant
    dm_req_v[1] = 1'b1; dm_we_v[1] = 1'b0; dm_addr_v[1] = 6'h08;
    step();
    dm_req_v[1] = 1'b0;
    wait_ready(1, 12, cyc, gi, gd, en_cnt);
    check("drop_lat", 64'(cyc + 1), 64'd5);
    check("drop_data", dm_rdata_v[1], 64'hDEAD_BEEF_CAFE_F00D);
    step();
    check("drop_idle", 64'({busy_v[1], dm_ready_v[1]}), 64'd0);

    // Random traffic on the MEM_LAT=1 instance against a transaction-level model
    if_p = 1'b0; dm_p = 1'b0; scnt = 0;
    last_dm = 64'hDEAD_BEEF_CAFE_F00D;
    for (int it = 0; it < 60; it++) begin
      if (!if_p && ($urandom_range(0, 1) == 1)) begin
        if_p = 1'b1;
        if_addr_v[0] = AW'($urandom_range(0, 63));
      end
      if (!dm_p && ($urandom_range(0, 1) == 1)) begin
        dm_p = 1'b1;
        dm_we_v[0] = 1'($urandom_range(0, 1));
        dm_addr_v[0] = AW'($urandom_range(0, 63));
        dm_wdata_v[0] = {$urandom, $urandom};
      end
      if_req_v[0] = if_p;
      dm_req_v[0] = dm_p;
      if (!if_p && !dm_p) begin
        step();
        continue;
      end
      win_if = if_p && (!dm_p || scnt == SMAX);
      if (win_if) scnt = 0;
      else if (if_p && scnt < SMAX) scnt++;
      exp_lat = (!win_if && dm_we_v[0]) ? 2 : 3;
      wait_ready(0, 12, cyc, gi, gd, en_cnt);
      check("rnd_lat", 64'(cyc), 64'(exp_lat));
      check("rnd_owner", 64'({gi, gd}), win_if ? 64'd2 : 64'd1);
      check("rnd_mem_en_count", 64'(en_cnt), 64'd1);
      if (win_if) begin
        exp_word = ref_ram[if_addr_v[0][5:3]];
        check("rnd_if_rdata", 64'(if_rdata_v[0]),
              if_addr_v[0][2] ? 64'(exp_word[63:32]) : 64'(exp_word[31:0]));
        if_p = 1'b0;
      end else begin
        if (dm_we_v[0]) ref_ram[dm_addr_v[0][5:3]] = dm_wdata_v[0];
        else last_dm = ref_ram[dm_addr_v[0][5:3]];
        check("rnd_dm_rdata", dm_rdata_v[0], last_dm);
        dm_p = 1'b0;
      end
      step();
      if_req_v[0] = if_p;
      dm_req_v[0] = dm_p;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
